i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
I2C target (slave) responder that terminates the two-wire bus from the board controller and exposes a small byte-wide register file interface to the PWM core (compare-target bytes etc.). It supports pointer-based writes with auto-increment and reads via repeated START. Open-drain SDA is modelled as an output-enable (drive-low) signal, with the pad in top. SCL is input-only; no clock stretching.

Parameters:
DEV_ADDR, 7'h52, 7-bit target address matched against first byte[7:1].
NREGS, 4, number of byte registers; pointer width PW = $clog2(NREGS).
SYNC_STAGES, 2, synchronizer depth for scl_i/sda_i.

Ports:
clk_USB  input  1  system clock (12 MHz); all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  SCL pad input, asynchronous.
sda_i  input  1  SDA pad input, asynchronous.
sda_oe  output  1  1 = pull SDA low; 0 = release (high-Z).
reg_addr  output  PW  current register pointer.
reg_wdata  output  8  write data, valid with reg_wr_en.
reg_wr_en  output  1  one-cycle write strobe to reg_addr.
reg_rdata  input  8  read data for reg_addr (combinational from register file).
busy  output  1  high from address match until STOP/START/NACK-exit.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, busy=0, state=IDLE. Reset mid-transfer releases SDA immediately (async).
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detect. Detection latency is SYNC_STAGES+1 clocks. Bus SCL high/low phases >= 6 clk_USB cycles.
- START = sda fall while scl high; STOP = sda rise while scl high. Both take priority over bit processing in any state.
- START (incl. repeated) -> ADDR, bit counter=0, sda_oe=0. STOP -> IDLE, busy=0. reg_addr is retained across both.
- Bits are sampled on detected scl rise. sda_oe changes only on detected scl fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits.
  - byte[7:1]==DEV_ADDR: at next scl fall, sda_oe=1, busy=1, go ADDR_ACK.
  - No match: go IGNORE; sda_oe stays 0 until START/STOP.
- ADDR_ACK: at the 9th scl fall, release SDA.
  - R/W=0: go PTR.
  - R/W=1: load shift reg from reg_rdata, drive MSB (sda_oe=~bit7), go RDATA.
- PTR: after 8 bits:
  - byte < NREGS: reg_addr=byte[PW-1:0], ACK, then WDATA.
  - Otherwise: NACK (no drive), go IGNORE, reg_addr unchanged.
- WDATA: on the 8th scl rise, reg_wdata=byte and reg_wr_en=1 for exactly one clock. Then ACK and go WDATA_ACK. After the 9th fall, reg_addr increments modulo NREGS (NREGS-1 wraps to 0), return to WDATA.
- RDATA: shift out bits 6..0 on successive scl falls. After the 8th bit, at scl fall release SDA, go RDATA_ACK.
- RDATA_ACK: sample sda on scl rise.
  - 0 (ACK): reg_addr++ mod NREGS. At the following fall, load reg_rdata (new pointer) and drive its MSB.
  - 1 (NACK): go IGNORE, sda_oe=0.
- IGNORE: no drive, no strobes, busy=0; exits only on START/STOP.
- reg_wr_en is never asserted outside WDATA. sda_oe is never asserted in IDLE/IGNORE.

Test Plan:
- START, 0xA4, 0x00, 0x34, STOP -> ACK on all 3 bytes; single reg_wr_en pulse with reg_addr=0, reg_wdata=0x34; busy falls after STOP.
- START, 0xA4, 0x03, 0xAA, 0xBB, STOP -> writes (3,0xAA) then (0,0xBB) (wrap); reg_addr=1 at end.
- START, 0xA6 (addr 0x53), 0x00 -> SDA never pulled low, no reg_wr_en, busy=0.
- Regs {0x11,0x22,0x33,0x44}: START, 0xA4, 0x01, repeated START, 0xA5, read byte master-ACK, read byte master-NACK, STOP -> returns 0x22 then 0x33; reg_addr=2; SDA released after NACK.
- START, 0xA4, 0x07 -> pointer byte NACKed; subsequent 0x55 ignored (no strobe, no ACK); reg_addr unchanged.
- Assert rst_n low while target drives ACK -> sda_oe=0 within the same cycle, all outputs at reset values; next full write transaction succeeds normally.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - byte-wide register-file bus between the I2C target and its register bank
//
// Signals:
//   reg_addr   current register pointer (driven by the I2C target)
//   reg_wdata  write data, valid while reg_wr_en is high
//   reg_wr_en  one-cycle write strobe to reg_addr
//   reg_rdata  combinational read data for reg_addr (driven by the register bank)
// Modports: master = I2C target side, slave = register bank side.

interface i2c_target_regs_if #(
    parameter int PW = 2
);
    logic [PW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_wr_en;
    logic [7:0]    reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_wr_en,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_wr_en,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target responder exposing a byte-wide register file
//
// Pointer-based writes with auto-increment, reads through repeated START.
// SDA is open-drain: sda_oe=1 pulls the line low, the pad lives in the top level.
// No clock stretching; SCL is input only.
//
// Ports:
//   clk_USB  system clock, rising edge
//   rst_n    asynchronous active-low reset
//   scl_i    SCL pad input (asynchronous)
//   sda_i    SDA pad input (asynchronous)
//   sda_oe   1 = pull SDA low, 0 = release
//   busy     high from address match until STOP/START/NACK exit
//   rbus     register-file bus (master modport): reg_addr/reg_wdata/reg_wr_en out, reg_rdata in

module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h52,
    parameter int         NREGS       = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk_USB,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    i2c_target_regs_if.master rbus
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    // Synchronizers reset to 1 so an idle bus produces no edges after reset.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk_USB or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= (scl_sync << 1) | SYNC_STAGES'(scl_i);
            sda_sync <= (sda_sync << 1) | SYNC_STAGES'(sda_i);
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic [PW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          reg_wr_en_q, reg_wr_en_d;

    logic [7:0]    rx_byte;
    logic [PW-1:0] addr_inc;
    logic          ptr_ok;

    // Byte as it stands including the bit sampled on the current SCL rise.
    assign rx_byte  = {shreg_q[6:0], sda_s};
    assign addr_inc = (reg_addr_q == PW'(NREGS - 1)) ? '0 : reg_addr_q + PW'(1);
    assign ptr_ok   = 32'(shreg_q) < 32'(NREGS);

    always_ff @(posedge clk_USB or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_en_q <= reg_wr_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_en_d = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end

                ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && rx_byte[7:1] != DEV_ADDR)
                            state_d = IGNORE;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        rw_d     = shreg_q[0];
                        state_d  = ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            shreg_d   = rbus.reg_rdata;
                            sda_oe_d  = ~rbus.reg_rdata[7];
                            bit_cnt_d = 4'd1;
                            state_d   = RDATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = PTR;
                        end
                    end
                end

                PTR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (ptr_ok) begin
                            reg_addr_d = shreg_q[PW-1:0];
                            sda_oe_d   = 1'b1;
                            state_d    = PTR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end

                PTR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = WDATA;
                    end
                end

                WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shreg_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            reg_wdata_d = rx_byte;
                            reg_wr_en_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = WDATA_ACK;
                    end
                end

                WDATA_ACK: begin
                    // Pointer moves only after the ACK clock, so the strobe saw the old address.
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = addr_inc;
                        bit_cnt_d  = '0;
                        state_d    = WDATA;
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RDATA_ACK;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                            state_d  = IGNORE;
                        end else begin
                            reg_addr_d = addr_inc;
                        end
                    end else if (scl_fall) begin
                        // reg_rdata already reflects the incremented pointer here.
                        shreg_d   = rbus.reg_rdata;
                        sda_oe_d  = ~rbus.reg_rdata[7];
                        bit_cnt_d = 4'd1;
                        state_d   = RDATA;
                    end
                end

                IGNORE: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end

                default: begin
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    assign sda_oe         = sda_oe_q;
    assign busy           = busy_q;
    assign rbus.reg_addr  = reg_addr_q;
    assign rbus.reg_wdata = reg_wdata_q;
    assign rbus.reg_wr_en = reg_wr_en_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed self-checking bench for i2c_target_regs

module tb_i2c_target_regs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe;
    logic busy;
    logic sda_bus;

    logic [7:0] regs [4];

    int checks = 0;
    int errors = 0;

    i2c_target_regs_if #(.PW(2)) rbus ();

    assign sda_bus        = sda_m & ~sda_oe;
    assign rbus.reg_rdata = regs[rbus.reg_addr];

    i2c_target_regs #(
        .DEV_ADDR    (7'h52),
        .NREGS       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_USB (clk),
        .rst_n   (rst_n),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .rbus    (rbus)
    );

    always #5 clk = ~clk;

    // Write-strobe and SDA-drive monitor
    logic [3:0] wr_cnt = '0;
    logic [1:0] wa [16];
    logic [7:0] wd [16];
    logic       wr_prev = 1'b0;
    int         wr_long = 0;
    int         oe_cnt = 0;

    always @(negedge clk) begin
        if (rbus.reg_wr_en) begin
            wa[wr_cnt] <= rbus.reg_addr;
            wd[wr_cnt] <= rbus.reg_wdata;
            wr_cnt     <= wr_cnt + 4'd1;
        end
        if (rbus.reg_wr_en && wr_prev) wr_long <= wr_long + 1;
        wr_prev <= rbus.reg_wr_en;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; half();
        scl_m = 1'b1; half();
        sda_m = 1'b0; half();
        scl_m = 1'b0; half();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; half();
        scl_m = 1'b1; half();
        sda_m = 1'b1; half();
        half();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; half();
            scl_m = 1'b1; half();
            scl_m = 1'b0; half();
        end
    endtask

    task automatic get_ack(output logic ack);
        sda_m = 1'b1; half();
        scl_m = 1'b1; half();
        #1 ack = sda_bus;
        scl_m = 1'b0; half();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        get_ack(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            half();
            scl_m = 1'b1; half();
            #1 d[i] = sda_bus;
            scl_m = 1'b0;
        end
        half();
        sda_m = ~mack; half();
        scl_m = 1'b1; half();
        scl_m = 1'b0; half();
        sda_m = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a1, a2, a3, a4;
        logic [7:0] d1, d2;
        logic [3:0] wr_base;
        int         oe_base;

        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;

        // Reset
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_reg_addr", 32'(rbus.reg_addr), 0);
        check("rst_reg_wdata", 32'(rbus.reg_wdata), 0);
        check("rst_reg_wr_en", 32'(rbus.reg_wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        half();

        // T1: single write 0x34 to register 0
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA4, a1);
        write_byte(8'h00, a2);
        write_byte(8'h34, a3);
        check("t1_acks", 32'({a1, a2, a3}), 0);
        check("t1_busy_before_stop", 32'(busy), 1);
        i2c_stop();
        check("t1_busy_after_stop", 32'(busy), 0);
        check("t1_wr_count", 32'(4'(wr_cnt - wr_base)), 1);
        check("t1_wr_addr", 32'(wa[wr_base]), 0);
        check("t1_wr_data", 32'(wd[wr_base]), 32'h34);
        check("t1_reg_addr", 32'(rbus.reg_addr), 1);

        // T2: auto-increment with wrap from 3 to 0
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA4, a1);
        write_byte(8'h03, a2);
        write_byte(8'hAA, a3);
        write_byte(8'hBB, a4);
        i2c_stop();
        check("t2_acks", 32'({a1, a2, a3, a4}), 0);
        check("t2_wr_count", 32'(4'(wr_cnt - wr_base)), 2);
        check("t2_wr0_addr", 32'(wa[wr_base]), 3);
        check("t2_wr0_data", 32'(wd[wr_base]), 32'hAA);
        check("t2_wr1_addr", 32'(wa[4'(wr_base + 4'd1)]), 0);
        check("t2_wr1_data", 32'(wd[4'(wr_base + 4'd1)]), 32'hBB);
        check("t2_reg_addr", 32'(rbus.reg_addr), 1);

        // T3: wrong device address 0x53
        wr_base = wr_cnt;
        oe_base = oe_cnt;
        i2c_start();
        write_byte(8'hA6, a1);
        check("t3_addr_nack", 32'(a1), 1);
        check("t3_busy", 32'(busy), 0);
        write_byte(8'h00, a2);
        check("t3_data_nack", 32'(a2), 1);
        i2c_stop();
        check("t3_oe_never", 32'(oe_cnt - oe_base), 0);
        check("t3_wr_count", 32'(4'(wr_cnt - wr_base)), 0);

        // T4: pointer 1, repeated START, read two bytes
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA4, a1);
        write_byte(8'h01, a2);
        i2c_start();
        write_byte(8'hA5, a3);
        check("t4_acks", 32'({a1, a2, a3}), 0);
        read_byte(1'b1, d1);
        read_byte(1'b0, d2);
        check("t4_rd0", 32'(d1), 32'h22);
        check("t4_rd1", 32'(d2), 32'h33);
        check("t4_oe_after_nack", 32'(sda_oe), 0);
        check("t4_busy_after_nack", 32'(busy), 0);
        i2c_stop();
        check("t4_reg_addr", 32'(rbus.reg_addr), 2);
        check("t4_wr_count", 32'(4'(wr_cnt - wr_base)), 0);

        // T5: out-of-range pointer
        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA4, a1);
        check("t5_addr_ack", 32'(a1), 0);
        oe_base = oe_cnt;
        write_byte(8'h07, a2);
        check("t5_ptr_nack", 32'(a2), 1);
        check("t5_busy", 32'(busy), 0);
        write_byte(8'h55, a3);
        check("t5_data_nack", 32'(a3), 1);
        i2c_stop();
        check("t5_oe_never", 32'(oe_cnt - oe_base), 0);
        check("t5_wr_count", 32'(4'(wr_cnt - wr_base)), 0);
        check("t5_reg_addr", 32'(rbus.reg_addr), 2);

        // T6: reset while target drives address ACK
        i2c_start();
        send_bits(8'hA4);
        check("t6_oe_before_rst", 32'(sda_oe), 1);
        check("t6_busy_before_rst", 32'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda_oe", 32'(sda_oe), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_reg_addr", 32'(rbus.reg_addr), 0);
        check("t6_rst_reg_wdata", 32'(rbus.reg_wdata), 0);
        check("t6_rst_reg_wr_en", 32'(rbus.reg_wr_en), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sda_m = 1'b1; half();
        scl_m = 1'b1; half();
        half();

        wr_base = wr_cnt;
        i2c_start();
        write_byte(8'hA4, a1);
        write_byte(8'h02, a2);
        write_byte(8'h5A, a3);
        i2c_stop();
        check("t6_acks", 32'({a1, a2, a3}), 0);
        check("t6_wr_count", 32'(4'(wr_cnt - wr_base)), 1);
        check("t6_wr_addr", 32'(wa[wr_base]), 2);
        check("t6_wr_data", 32'(wd[wr_base]), 32'h5A);
        check("t6_reg_addr", 32'(rbus.reg_addr), 3);

        check("wr_en_single_cycle", 32'(wr_long), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
